// File: rtl/calc1_port_master.sv
// ---------------------------------------------------------------------------
// calc1_port_master
//
// Initiator for a single calc1 request/response port. An upstream agent hands
// over one complete operation (command + two operands) on a valid/ready
// handshake. The block then drives the two-cycle calc1 request sequence,
// waits for the port's response (or a timeout) and presents the captured
// result, together with its latency, on a second valid/ready handshake.
// Only one operation is ever outstanding on the port.
//
// Parameters
//   TIMEOUT : WAIT cycles without a response before giving up (1..2^CNT_W-1)
//   CNT_W   : width of the wait/latency counter
//
// Ports
//   c_clk, reset              clock (rising edge), async active-high reset
//   op_valid/op_ready         upstream operation handshake
//   op_cmd, op_data1/2        operation command and operands
//   req_cmd_out/req_data_out  request drive into calc1
//   out_resp/out_data         response from calc1
//   res_valid/res_ready       downstream result handshake
//   res_resp/res_data         captured response code and data
//   res_latency               cycles from the operand-2 cycle to the response
//   res_timeout               operation ended by timeout
//   err_spurious              sticky: response seen with nothing outstanding
// ---------------------------------------------------------------------------
module calc1_port_master #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_cmd,
  input  logic [31:0]      op_data1,
  input  logic [31:0]      op_data2,
  output logic [3:0]       req_cmd_out,
  output logic [31:0]      req_data_out,
  input  logic [1:0]       out_resp,
  input  logic [31:0]      out_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_resp,
  output logic [31:0]      res_data,
  output logic [CNT_W-1:0] res_latency,
  output logic             res_timeout,
  output logic             err_spurious
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND1 = 3'd1,
    SEND2 = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]      data2_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_plus;
  logic [CNT_W-1:0] cnt_sat_inc;
  logic             resp_seen;
  logic             timeout_hit;

  // cnt_plus wraps only when cnt is all ones; since TIMEOUT >= 1 the
  // wrapped value can never match, so no false timeout is possible.
  assign cnt_plus    = cnt + CNT_W'(1);
  assign cnt_sat_inc = (cnt == '1) ? cnt : cnt_plus;
  assign resp_seen   = (out_resp != 2'd0);
  assign timeout_hit = (cnt_plus == TIMEOUT_C);

  // State register
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A response wins over a timeout on the same edge, which
  // falls out naturally because both lead to DONE and the datapath below
  // checks the response first.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (op_valid) begin
          state_next = (op_cmd == 4'd0) ? DONE : SEND1;
        end
      end
      SEND1: state_next = SEND2;
      SEND2: state_next = WAIT;
      WAIT: begin
        if (resp_seen || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs depend only on the state
  always_comb begin
    op_ready  = (state == IDLE);
    res_valid = (state == DONE);
  end

  // Request drive, counter and result capture. The request registers are
  // loaded on the accept edge so the command/operand-1 beat appears in the
  // very first cycle after accept.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      req_cmd_out  <= 4'd0;
      req_data_out <= 32'd0;
      data2_q      <= 32'd0;
      cnt          <= '0;
      res_resp     <= 2'd0;
      res_data     <= 32'd0;
      res_latency  <= '0;
      res_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (op_valid) begin
            if (op_cmd != 4'd0) begin
              req_cmd_out  <= op_cmd;
              req_data_out <= op_data1;
              data2_q      <= op_data2;
            end else begin
              // A no-op never touches the port and completes with a
              // zeroed result.
              res_resp    <= 2'd0;
              res_data    <= 32'd0;
              res_latency <= '0;
              res_timeout <= 1'b0;
            end
          end
        end
        SEND1: begin
          req_cmd_out  <= 4'd0;
          req_data_out <= data2_q;
        end
        SEND2: begin
          req_cmd_out  <= 4'd0;
          req_data_out <= 32'd0;
          cnt          <= '0;
        end
        WAIT: begin
          if (resp_seen) begin
            res_resp    <= out_resp;
            res_data    <= out_data;
            res_latency <= cnt_plus;
            res_timeout <= 1'b0;
          end else begin
            cnt <= cnt_sat_inc;
            if (timeout_hit) begin
              res_resp    <= 2'd0;
              res_data    <= 32'd0;
              res_latency <= TIMEOUT_C;
              res_timeout <= 1'b1;
            end
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase

      // Any response outside WAIT has no matching request
      if (resp_seen && (state != WAIT)) begin
        err_spurious <= 1'b1;
      end
    end
  end

endmodule
